usr_seq: RTL
============

Name: usr_seq

Overview:
Parametrised universal shift register with a sequenced multi-step operation engine. A single start request performs a parallel load, or N consecutive logical/arithmetic/rotate shifts in either direction, one step per clock, then reports completion. It is the next generation of the team's 4-bit universal shift register. It sits between a control FSM and serial/parallel datapaths.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, $clog2(2*WIDTH+1), width of the step-count input; allows up to 2*WIDTH steps

Ports:
clk  in  1  rising-edge clock
clr_n  in  1  asynchronous active-low reset
start  in  1  operation request; accepted only when busy==0
mode  in  3  operation code, sampled with start
count  in  CNT_W  number of shift steps, sampled with start
data_in  in  WIDTH  parallel load value, sampled with start
ser_in_msb  in  1  serial fill bit entering at MSB (right shifts)
ser_in_lsb  in  1  serial fill bit entering at LSB (left shifts)
out  out  WIDTH  register contents
ser_out_msb  out  1  equals out[WIDTH-1]
ser_out_lsb  out  1  equals out[0]
busy  out  1  high while in RUN
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (clr_n low, asynchronous): out=0, busy=0, done=0, state=IDLE, latched mode/count/data=0. Release is synchronous to clk. A reset that arrives mid-RUN aborts the operation with no done pulse.
- Modes:
  - 000 HOLD
  - 001 SHR: out <= {ser_in_msb, out[W-1:1]}
  - 010 SHL: out <= {out[W-2:0], ser_in_lsb}
  - 011 ROR
  - 100 ROL
  - 101 LOAD: out <= latched data_in
  - 110 ASR: MSB is replicated
  - 111 reserved, behaves as HOLD
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE with start=1: latch mode, count and data_in; go to RUN. out is unchanged on this edge.
  - Exception: if mode is HOLD/reserved, or a shift mode with count==0, go straight to DONE.
  - RUN: each edge performs one step and decrements the remaining count.
    - LOAD always takes exactly one step, whatever the count.
    - Leave RUN on the edge that performs the final step; go to DONE.
  - DONE: done=1 for exactly one cycle. Next state is IDLE, or RUN/DONE if start=1 in this cycle (back-to-back operations allowed).
- busy=1 exactly while the state is RUN. start, mode, count and data_in are ignored while busy.
- Latency:
  - start sampled at edge T; a shift with count=N updates out at edges T+1..T+N; done is high in the cycle after edge T+N.
  - LOAD updates out at T+1, with done in the following cycle.
  - Zero-step operations: done is high in the cycle after edge T.
- ser_in_msb and ser_in_lsb are sampled live at every RUN edge, not latched, so callers can stream a serial word in.
- Rotates with count >= WIDTH wrap naturally; no modulo reduction is applied.
- ASR with count >= WIDTH saturates to all-sign bits.
- done and busy are never high simultaneously.

Decomposition:
- Shared package usr_pkg:
  - mode localparams: MODE_HOLD, MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_LOAD, MODE_ASR
  - state encoding ST_IDLE, ST_RUN, ST_DONE
- One sub-module, usr_step: purely combinational next-value function (mode, out, ser_in_msb, ser_in_lsb, load data) -> next out.
- usr_seq holds the FSM, the step counter and the registers.

Test Plan:
All with WIDTH=8.
- Reset: clr_n low asynchronously mid-RUN (SHL, count=5, after 2 steps) -> out=0x00 and busy=0 immediately; no done pulse afterwards.
- LOAD: start, mode=101, data_in=0xA5 -> out=0xA5 one edge after the start edge; done pulses once; busy high for exactly 1 cycle.
- SHR streaming: out=0x00, SHR count=8, ser_in_msb driven 1,0,1,1,0,0,1,0 on successive RUN edges -> out=0x4D; busy high 8 cycles; done high in cycle 9.
- ROL wrap: out=0x81, ROL count=9 -> out=0x03. ASR: out=0x80, ASR count=3 -> out=0xF0.
- Zero/ignored: SHL count=0 -> done the next cycle with out unchanged. A start asserted during RUN (any mode) -> no effect on out or on the step total.
- Back-to-back: start=1 held in the DONE cycle with LOAD 0x3C -> out=0x3C one edge later, with no IDLE cycle between the two operations.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared encodings for the sequenced universal shift register: operation codes,
// FSM state values and the zero-step classification used when an operation is accepted.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // HOLD/reserved never step; shifts with a zero count have nothing to do; LOAD always steps once.
  function automatic logic is_zero_step(input logic [2:0] m, input logic cnt_zero);
    return (m == MODE_HOLD) || (m == MODE_RSVD) || ((m != MODE_LOAD) && cnt_zero);
  endfunction

endpackage

// File: rtl/usr_step.sv
// Single-step next-value function of the universal shift register (purely combinational).
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic             ser_in_msb_i,
  input  logic             ser_in_lsb_i,
  input  logic [WIDTH-1:0] load_i,
  output logic [WIDTH-1:0] nxt_o
);

  always_comb begin
    nxt_o = cur_i;
    case (mode_i)
      MODE_SHR:  nxt_o = {ser_in_msb_i, cur_i[WIDTH-1:1]};
      MODE_SHL:  nxt_o = {cur_i[WIDTH-2:0], ser_in_lsb_i};
      MODE_ROR:  nxt_o = {cur_i[0], cur_i[WIDTH-1:1]};
      MODE_ROL:  nxt_o = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
      MODE_LOAD: nxt_o = load_i;
      MODE_ASR:  nxt_o = {cur_i[WIDTH-1], cur_i[WIDTH-1:1]};
      default:   nxt_o = cur_i;
    endcase
  end

endmodule

// File: rtl/usr_seq.sv
// Universal shift register with a multi-step sequencer: one start performs a load or
// N shift/rotate steps, one per clock, then pulses done for a single cycle.
module usr_seq
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(2*WIDTH+1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  output logic [WIDTH-1:0] out,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [2:0]       mode_q,  mode_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [WIDTH-1:0] step_nxt;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .mode_i       (mode_q),
    .cur_i        (out_q),
    .ser_in_msb_i (ser_in_msb),
    .ser_in_lsb_i (ser_in_lsb),
    .load_i       (data_q),
    .nxt_o        (step_nxt)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    out_d   = out_q;
    if (state_q == ST_RUN) begin
      out_d = step_nxt;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q <= CNT_W'(1)) state_d = ST_DONE;
    end else begin
      // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
      state_d = ST_IDLE;
      if (start) begin
        mode_d  = mode;
        data_d  = data_in;
        cnt_d   = (mode == MODE_LOAD) ? CNT_W'(1) : count;
        state_d = is_zero_step(mode, count == '0) ? ST_DONE : ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      out_q   <= out_d;
    end
  end

  assign out         = out_q;
  assign ser_out_msb = out_q[WIDTH-1];
  assign ser_out_lsb = out_q[0];
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);

endmodule
